// File: rtl/key_event_latch.sv
// key_event_latch: debounced, latched press events from active-low KEY buttons (KEY_AUTOREPEAT_EN adds hold-to-repeat).
// Latency: KEY fall to press_pulse/key_down = 2 sync + DEBOUNCE_CYCLES cycles; pressed follows one cycle later.
// Backpressure: one pending event per key, cleared by consume; a press while pending sets sticky overrun.
module key_event_latch #(
    parameter int NUM_KEYS        = 2,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 20,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 5000000
) (
    input  logic                MAX10_CLK1_50,
    input  logic                reset,
    input  logic [NUM_KEYS-1:0] KEY,
    input  logic [NUM_KEYS-1:0] consume,
    output logic [NUM_KEYS-1:0] pressed,
    output logic [NUM_KEYS-1:0] press_pulse,
    output logic [NUM_KEYS-1:0] key_down,
    output logic [NUM_KEYS-1:0] overrun
);

    if (DEBOUNCE_CYCLES < 2 || REPEAT_PERIOD < 1 || REPEAT_PERIOD > REPEAT_DELAY) begin : g_param_check
        $error("key_event_latch: invalid timing parameters");
    end

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [NUM_KEYS-1:0] sync1;
    logic [NUM_KEYS-1:0] sync2;
    logic [NUM_KEYS-1:0] sample;
    logic [NUM_KEYS-1:0] kd_prev;
    logic [NUM_KEYS-1:0] rpt_pulse;
    logic [CNT_W-1:0]    cnt [NUM_KEYS];

    assign sample = ~sync2;

    always_ff @(posedge MAX10_CLK1_50) begin
        if (reset) begin
            sync1    <= '1;
            sync2    <= '1;
            key_down <= '0;
            kd_prev  <= '0;
            for (int i = 0; i < NUM_KEYS; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            sync1   <= KEY;
            sync2   <= sync1;
            kd_prev <= key_down;
            for (int i = 0; i < NUM_KEYS; i++) begin
                // Counter only runs while the sample disagrees with the accepted level.
                if (sample[i] == key_down[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_LAST) begin
                    key_down[i] <= ~key_down[i];
                    cnt[i]      <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

`ifdef KEY_AUTOREPEAT_EN
    localparam int                HOLD_W      = $clog2(REPEAT_DELAY + 1);
    localparam logic [HOLD_W-1:0] HOLD_FIRE   = HOLD_W'(REPEAT_DELAY);
    localparam logic [HOLD_W-1:0] HOLD_RELOAD = HOLD_W'(REPEAT_DELAY - REPEAT_PERIOD + 1);

    logic [HOLD_W-1:0] hold_cnt [NUM_KEYS];

    // Reloading below the fire value spaces later repeats by REPEAT_PERIOD.
    always_ff @(posedge MAX10_CLK1_50) begin
        for (int i = 0; i < NUM_KEYS; i++) begin
            if (reset || !key_down[i]) begin
                hold_cnt[i] <= '0;
            end else if (hold_cnt[i] == HOLD_FIRE) begin
                hold_cnt[i] <= HOLD_RELOAD;
            end else begin
                hold_cnt[i] <= hold_cnt[i] + 1'b1;
            end
        end
    end

    always_comb begin
        rpt_pulse = '0;
        for (int i = 0; i < NUM_KEYS; i++) begin
            rpt_pulse[i] = key_down[i] && (hold_cnt[i] == HOLD_FIRE);
        end
    end
`else
    assign rpt_pulse = '0;
`endif

    assign press_pulse = (key_down & ~kd_prev) | rpt_pulse;

    // A new event beats a same-cycle consume; overrun implies pressed, so consume always clears it.
    always_ff @(posedge MAX10_CLK1_50) begin
        if (reset) begin
            pressed <= '0;
            overrun <= '0;
        end else begin
            pressed <= (pressed & ~consume) | press_pulse;
            overrun <= (overrun & ~(consume & pressed)) | (press_pulse & pressed & ~consume);
        end
    end

endmodule

// File: tb/tb_key_event_latch.sv
// Bench for key_event_latch: row table plus hand-written corner sequences; press_pulse checked against a cycle scoreboard.
module tb_key_event_latch;

    localparam int DEB = 4;
`ifdef KEY_AUTOREPEAT_EN
    localparam bit AR = 1'b1;
`else
    localparam bit AR = 1'b0;
`endif

    logic       MAX10_CLK1_50 = 1'b0;
    logic       reset;
    logic [1:0] KEY;
    logic [1:0] consume;
    logic [1:0] pressed;
    logic [1:0] press_pulse;
    logic [1:0] key_down;
    logic [1:0] overrun;

    key_event_latch #(
        .NUM_KEYS        (2),
        .DEBOUNCE_CYCLES (DEB),
        .CNT_W           (20),
        .REPEAT_DELAY    (20),
        .REPEAT_PERIOD   (8)
    ) dut (
        .MAX10_CLK1_50 (MAX10_CLK1_50),
        .reset         (reset),
        .KEY           (KEY),
        .consume       (consume),
        .pressed       (pressed),
        .press_pulse   (press_pulse),
        .key_down      (key_down),
        .overrun       (overrun)
    );

    always #10 MAX10_CLK1_50 = ~MAX10_CLK1_50;

    int cyc = 0;
    always @(posedge MAX10_CLK1_50) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;
    bit mon_en   = 1'b0;
    int exp_q0 [$];
    int exp_q1 [$];

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s cyc=%0d actual=%0d expected=%0d", nm, cyc, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge MAX10_CLK1_50);
    endtask

    task automatic push_exp(input int k, input int when);
        if (k == 0) exp_q0.push_back(when);
        else        exp_q1.push_back(when);
    endtask

    task automatic pop_pulse(input int k);
        int e;
        if ((k == 0 && exp_q0.size() == 0) || (k == 1 && exp_q1.size() == 0)) begin
            checks++;
            failures++;
            $display("FAIL unexpected_pulse key=%0d actual_cyc=%0d expected=none", k, cyc);
        end else begin
            e = (k == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
            chk($sformatf("pulse_cycle_key%0d", k), cyc, e);
        end
    endtask

    always @(negedge MAX10_CLK1_50) begin
        if (mon_en) begin
            if (press_pulse[0] === 1'b1) pop_pulse(0);
            if (press_pulse[1] === 1'b1) pop_pulse(1);
        end
    end

    typedef struct {
        logic [1:0] key;
        logic [1:0] cm;
        int         n;
        logic [1:0] kd;
        logic [1:0] pr;
        logic [1:0] ov;
        int         p0;
        int         p1;
    } row_t;

    localparam int NROWS = 13;
    row_t rows [NROWS];

    initial begin
        int c;
        int prev;

        // key, consume(first cycle), cycles, exp key_down, pressed, overrun, pulse offsets
        rows[0]  = '{2'b11, 2'b00,  5, 2'b00, 2'b00, 2'b00, -1, -1};
        rows[1]  = '{2'b10, 2'b00, 10, 2'b01, 2'b01, 2'b00,  6, -1};
        rows[2]  = '{2'b10, 2'b00,  5, 2'b01, 2'b01, 2'b00, -1, -1};
        rows[3]  = '{2'b11, 2'b00, 10, 2'b00, 2'b01, 2'b00, -1, -1};
        rows[4]  = '{2'b10, 2'b00, 10, 2'b01, 2'b01, 2'b01,  6, -1};
        rows[5]  = '{2'b11, 2'b00, 10, 2'b00, 2'b01, 2'b01, -1, -1};
        rows[6]  = '{2'b11, 2'b01,  3, 2'b00, 2'b00, 2'b00, -1, -1};
        rows[7]  = '{2'b11, 2'b01,  3, 2'b00, 2'b00, 2'b00, -1, -1};
        rows[8]  = '{2'b01, 2'b00, 10, 2'b10, 2'b10, 2'b00, -1,  6};
        rows[9]  = '{2'b01, 2'b10,  1, 2'b10, 2'b00, 2'b00, -1, -1};
        rows[10] = '{2'b11, 2'b00, 10, 2'b00, 2'b00, 2'b00, -1, -1};
        rows[11] = '{2'b00, 2'b00, 10, 2'b11, 2'b11, 2'b00,  6,  6};
        rows[12] = '{2'b11, 2'b11, 10, 2'b00, 2'b00, 2'b00, -1, -1};

        reset   = 1'b1;
        KEY     = 2'b11;
        consume = 2'b00;
        tick(3);
        chk("rst_key_down", key_down, 0);
        chk("rst_pressed", pressed, 0);
        chk("rst_press_pulse", press_pulse, 0);
        chk("rst_overrun", overrun, 0);
        reset  = 1'b0;
        mon_en = 1'b1;
        tick(2);

        for (int r = 0; r < NROWS; r++) begin
            KEY     = rows[r].key;
            consume = rows[r].cm;
            if (rows[r].p0 >= 0) push_exp(0, cyc + rows[r].p0);
            if (rows[r].p1 >= 0) push_exp(1, cyc + rows[r].p1);
            tick(1);
            consume = 2'b00;
            tick(rows[r].n - 1);
            chk($sformatf("row%0d_key_down", r), key_down, rows[r].kd);
            chk($sformatf("row%0d_pressed", r), pressed, rows[r].pr);
            chk($sformatf("row%0d_overrun", r), overrun, rows[r].ov);
        end

        // Bounce on press, then bounce on release: exactly one event.
        c = cyc;
        push_exp(0, c + 20 + 2 + DEB);
        if (AR) begin
            push_exp(0, c + 26 + 20);
            push_exp(0, c + 26 + 28);
        end
        for (int i = 0; i < 20; i++) begin
            KEY[0] = ((i / 2) % 2 == 0) ? 1'b0 : 1'b1;
            tick(1);
        end
        KEY[0] = 1'b0;
        tick(10);
        chk("bounce_key_down", key_down, 2'b01);
        chk("bounce_pressed", pressed, 2'b01);
        consume = 2'b01;
        tick(1);
        consume = 2'b00;
        for (int i = 0; i < 20; i++) begin
            KEY[0] = ((i / 2) % 2 == 0) ? 1'b1 : 1'b0;
            tick(1);
        end
        KEY[0] = 1'b1;
        tick(10);
        chk("bounce_rel_key_down", key_down, 2'b00);
        chk("bounce_rel_pressed", pressed, AR ? 2'b01 : 2'b00);
        chk("bounce_rel_overrun", overrun, AR ? 2'b01 : 2'b00);
        consume = 2'b11;
        tick(1);
        consume = 2'b00;
        tick(2);

        // Pending key1, then a new press coinciding with consume keeps pressed set.
        c = cyc;
        KEY = 2'b01;
        push_exp(1, c + 2 + DEB);
        tick(10);
        chk("hs_pressed", pressed, 2'b10);
        KEY = 2'b11;
        tick(10);
        c = cyc;
        KEY = 2'b01;
        push_exp(1, c + 2 + DEB);
        tick(2 + DEB);
        consume = 2'b10;
        tick(1);
        consume = 2'b00;
        chk("hs_same_cycle_pressed", pressed, 2'b10);
        chk("hs_same_cycle_overrun", overrun, 2'b00);
        KEY = 2'b11;
        tick(10);

        // Reset with the debounce counter at 2 and key0 held through reset.
        KEY = 2'b10;
        tick(4);
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick(1);
            chk("inrst_key_down", key_down, 0);
            chk("inrst_pressed", pressed, 0);
            chk("inrst_press_pulse", press_pulse, 0);
            chk("inrst_overrun", overrun, 0);
        end
        reset = 1'b0;
        push_exp(0, cyc + 2 + DEB);
        tick(10);
        chk("postrst_key_down", key_down, 2'b01);
        chk("postrst_pressed", pressed, 2'b01);
        chk("postrst_overrun", overrun, 2'b00);
        KEY = 2'b11;
        tick(10);
        consume = 2'b11;
        tick(1);
        consume = 2'b00;
        tick(2);

        if (AR) begin
            // Hold key1 for 50 cycles, consuming each event one cycle after its pulse.
            c = cyc;
            KEY = 2'b01;
            push_exp(1, c + 6);
            push_exp(1, c + 6 + 20);
            push_exp(1, c + 6 + 28);
            push_exp(1, c + 6 + 36);
            push_exp(1, c + 6 + 44);
            prev = 0;
            for (int i = 0; i < 50; i++) begin
                tick(1);
                consume[1] = prev[0];
                prev = int'(press_pulse[1]);
            end
            KEY = 2'b11;
            consume[1] = prev[0];
            tick(1);
            consume = 2'b00;
            tick(30);
            chk("ar_pressed", pressed, 2'b00);
            chk("ar_overrun", overrun, 2'b00);
            chk("ar_key_down", key_down, 2'b00);
        end

        tick(5);
        chk("q0_outstanding", exp_q0.size(), 0);
        chk("q1_outstanding", exp_q1.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
